pass_scheduler: RTL and testbench

Layer-level sequencer for `token_engine`.
- Takes one layer's tiling descriptor and issues a pass for each (K-tile, D-tile) pair, K outer and D inner.
- Per pass it drives `PASS_START`, the pass flags and the four GLB base addresses, then waits for `pass_done`.
- Sits between the layer-configuration registers and `token_engine`; computes all addresses with running adders, no multipliers.

---
 rtl/pass_sched_pkg.sv | 24 ++
 rtl/pass_addr_gen.sv | 67 ++++++
 rtl/pass_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_pass_scheduler.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pass_sched_pkg.sv
// Shared types and constants for the layer pass scheduler.
//   state_t         : scheduler FSM states
//   FLAG_*          : bit positions inside pass_flags
//   LT_*            : layer_type encodings (passed through, never decoded here)
package pass_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_ADVANCE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int unsigned FLAG_WEIGHT = 0;
    localparam int unsigned FLAG_IFMAP  = 1;
    localparam int unsigned FLAG_BIAS   = 2;
    localparam int unsigned FLAG_FINAL  = 3;

    localparam logic [1:0] LT_POINTWISE = 2'd0;
    localparam logic [1:0] LT_DEPTHWISE = 2'd1;
    localparam logic [1:0] LT_STANDARD  = 2'd2;

endpackage

// File: rtl/pass_addr_gen.sv
// Four GLB address accumulators driven by running adders.
//   load   : take the layer bases and capture strides plus ifmap base
//   step_d : next D-tile  (ifmap and weight advance)
//   step_k : next K-tile  (ifmap rewinds, weight/bias/opsum advance)
//   *_addr : registered current pass addresses (modulo 2^ADDR_WIDTH)
module pass_addr_gen #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step_d,
    input  logic                  step_k,
    input  logic [ADDR_WIDTH-1:0] ifmap_base,
    input  logic [ADDR_WIDTH-1:0] weight_base,
    input  logic [ADDR_WIDTH-1:0] bias_base,
    input  logic [ADDR_WIDTH-1:0] opsum_base,
    input  logic [ADDR_WIDTH-1:0] ifmap_stride,
    input  logic [ADDR_WIDTH-1:0] weight_stride,
    input  logic [ADDR_WIDTH-1:0] bias_stride,
    input  logic [ADDR_WIDTH-1:0] opsum_stride,
    output logic [ADDR_WIDTH-1:0] ifmap_addr,
    output logic [ADDR_WIDTH-1:0] weight_addr,
    output logic [ADDR_WIDTH-1:0] bias_addr,
    output logic [ADDR_WIDTH-1:0] opsum_addr
);

    logic [ADDR_WIDTH-1:0] ifmap_base_q;
    logic [ADDR_WIDTH-1:0] ifmap_stride_q;
    logic [ADDR_WIDTH-1:0] weight_stride_q;
    logic [ADDR_WIDTH-1:0] bias_stride_q;
    logic [ADDR_WIDTH-1:0] opsum_stride_q;

    // Accumulators; weight keeps running across K-tiles, ifmap rewinds per K-tile.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifmap_base_q    <= '0;
            ifmap_stride_q  <= '0;
            weight_stride_q <= '0;
            bias_stride_q   <= '0;
            opsum_stride_q  <= '0;
            ifmap_addr      <= '0;
            weight_addr     <= '0;
            bias_addr       <= '0;
            opsum_addr      <= '0;
        end else if (load) begin
            ifmap_base_q    <= ifmap_base;
            ifmap_stride_q  <= ifmap_stride;
            weight_stride_q <= weight_stride;
            bias_stride_q   <= bias_stride;
            opsum_stride_q  <= opsum_stride;
            ifmap_addr      <= ifmap_base;
            weight_addr     <= weight_base;
            bias_addr       <= bias_base;
            opsum_addr      <= opsum_base;
        end else if (step_d) begin
            ifmap_addr  <= ifmap_addr + ifmap_stride_q;
            weight_addr <= weight_addr + weight_stride_q;
        end else if (step_k) begin
            ifmap_addr  <= ifmap_base_q;
            weight_addr <= weight_addr + weight_stride_q;
            bias_addr   <= bias_addr + bias_stride_q;
            opsum_addr  <= opsum_addr + opsum_stride_q;
        end
    end

endmodule

// File: rtl/pass_scheduler.sv
// Layer-level sequencer: issues one pass per (K-tile, D-tile), K outer, D inner.
//   layer_start/abort, descriptor inputs : layer request from config registers
//   PASS_START, pass_*, BASE_*           : pass request to token_engine
//   pass_done                            : pass completion from token_engine
//   layer_busy, layer_done, cur_*_idx    : status
// All outputs are registered.
module pass_scheduler
    import pass_sched_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned BYTE_CNT_WIDTH = 16,
    parameter int unsigned FLAG_WIDTH     = 4,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      layer_start,
    input  logic                      layer_abort,
    input  logic [1:0]                layer_type,
    input  logic [CNT_WIDTH-1:0]      num_k_tiles,
    input  logic [CNT_WIDTH-1:0]      num_d_tiles,
    input  logic [BYTE_CNT_WIDTH-1:0] tile_n,
    input  logic [ADDR_WIDTH-1:0]     ifmap_base,
    input  logic [ADDR_WIDTH-1:0]     weight_base,
    input  logic [ADDR_WIDTH-1:0]     bias_base,
    input  logic [ADDR_WIDTH-1:0]     opsum_base,
    input  logic [ADDR_WIDTH-1:0]     ifmap_stride,
    input  logic [ADDR_WIDTH-1:0]     weight_stride,
    input  logic [ADDR_WIDTH-1:0]     bias_stride,
    input  logic [ADDR_WIDTH-1:0]     opsum_stride,
    output logic                      PASS_START,
    output logic [1:0]                pass_layer_type,
    output logic [BYTE_CNT_WIDTH-1:0] pass_tile_n,
    output logic [FLAG_WIDTH-1:0]     pass_flags,
    output logic [ADDR_WIDTH-1:0]     BASE_IFMAP,
    output logic [ADDR_WIDTH-1:0]     BASE_WEIGHT,
    output logic [ADDR_WIDTH-1:0]     BASE_BIAS,
    output logic [ADDR_WIDTH-1:0]     BASE_OPSUM,
    input  logic                      pass_done,
    output logic                      layer_busy,
    output logic                      layer_done,
    output logic [CNT_WIDTH-1:0]      cur_k_idx,
    output logic [CNT_WIDTH-1:0]      cur_d_idx
);

    state_t                    state_q;
    state_t                    state_d;
    logic [CNT_WIDTH-1:0]      k_q;
    logic [CNT_WIDTH-1:0]      d_q;
    logic [CNT_WIDTH-1:0]      k_d;
    logic [CNT_WIDTH-1:0]      d_d;
    logic [CNT_WIDTH-1:0]      nk_q;
    logic [CNT_WIDTH-1:0]      nd_q;
    logic [CNT_WIDTH-1:0]      nd_cur;
    logic [1:0]                layer_type_q;
    logic [BYTE_CNT_WIDTH-1:0] tile_n_q;
    logic [FLAG_WIDTH-1:0]     flags_q;
    logic [FLAG_WIDTH-1:0]     flags_d;
    logic                      pass_start_q;
    logic                      layer_done_q;
    logic                      busy_q;
    logic                      capture;
    logic                      addr_load;
    logic                      addr_step_d;
    logic                      addr_step_k;
    logic                      d_last;
    logic                      k_last;

    // Address accumulators
    pass_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_gen (
        .clk           (clk),
        .rst           (rst),
        .load          (addr_load),
        .step_d        (addr_step_d),
        .step_k        (addr_step_k),
        .ifmap_base    (ifmap_base),
        .weight_base   (weight_base),
        .bias_base     (bias_base),
        .opsum_base    (opsum_base),
        .ifmap_stride  (ifmap_stride),
        .weight_stride (weight_stride),
        .bias_stride   (bias_stride),
        .opsum_stride  (opsum_stride),
        .ifmap_addr    (BASE_IFMAP),
        .weight_addr   (BASE_WEIGHT),
        .bias_addr     (BASE_BIAS),
        .opsum_addr    (BASE_OPSUM)
    );

    // Next-state, counter and flag logic
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        d_d         = d_q;
        capture     = 1'b0;
        addr_load   = 1'b0;
        addr_step_d = 1'b0;
        addr_step_k = 1'b0;
        flags_d     = '0;
        d_last      = (d_q == nd_q - CNT_WIDTH'(1));
        k_last      = (k_q == nk_q - CNT_WIDTH'(1));
        // Descriptor is not captured yet on the start edge, so read it live there.
        nd_cur      = (state_q == ST_IDLE) ? num_d_tiles : nd_q;

        unique case (state_q)
            ST_IDLE: begin
                if (layer_start) begin
                    capture   = 1'b1;
                    addr_load = 1'b1;
                    k_d       = '0;
                    d_d       = '0;
                    if ((num_k_tiles == '0) || (num_d_tiles == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (pass_done) begin
                    state_d = ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                if (!d_last) begin
                    d_d         = d_q + CNT_WIDTH'(1);
                    addr_step_d = 1'b1;
                    state_d     = ST_ISSUE;
                end else if (!k_last) begin
                    d_d         = '0;
                    k_d         = k_q + CNT_WIDTH'(1);
                    addr_step_k = 1'b1;
                    state_d     = ST_ISSUE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over everything, including a same-cycle pass_done.
        if (layer_abort && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            k_d         = k_q;
            d_d         = d_q;
            addr_step_d = 1'b0;
            addr_step_k = 1'b0;
        end

        flags_d[FLAG_WEIGHT] = 1'b1;
        flags_d[FLAG_IFMAP]  = 1'b1;
        flags_d[FLAG_BIAS]   = (d_d == '0);
        flags_d[FLAG_FINAL]  = (d_d == nd_cur - CNT_WIDTH'(1));
    end

    // State and registered outputs; pulses are registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            d_q          <= '0;
            nk_q         <= '0;
            nd_q         <= '0;
            layer_type_q <= '0;
            tile_n_q     <= '0;
            flags_q      <= '0;
            pass_start_q <= 1'b0;
            layer_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            d_q     <= d_d;
            if (capture) begin
                nk_q         <= num_k_tiles;
                nd_q         <= num_d_tiles;
                layer_type_q <= layer_type;
                tile_n_q     <= tile_n;
            end
            if (state_d == ST_ISSUE) begin
                flags_q <= flags_d;
            end
            pass_start_q <= (state_d == ST_ISSUE);
            layer_done_q <= (state_d == ST_DONE);
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    assign PASS_START      = pass_start_q;
    assign layer_done      = layer_done_q;
    assign layer_busy      = busy_q;
    assign pass_flags      = flags_q;
    assign pass_layer_type = layer_type_q;
    assign pass_tile_n     = tile_n_q;
    assign cur_k_idx       = k_q;
    assign cur_d_idx       = d_q;

endmodule

// File: tb/tb_pass_scheduler.sv
// Self-checking bench for pass_scheduler: a pass-list model built from the
// closed-form address rules, a per-cycle compare process, and directed layers.
module tb_pass_scheduler;

    localparam int unsigned AW = 32;
    localparam int unsigned BW = 16;
    localparam int unsigned FW = 4;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          layer_start = 1'b0;
    logic          layer_abort = 1'b0;
    logic [1:0]    layer_type = '0;
    logic [CW-1:0] num_k_tiles = '0;
    logic [CW-1:0] num_d_tiles = '0;
    logic [BW-1:0] tile_n = '0;
    logic [AW-1:0] ifmap_base = '0;
    logic [AW-1:0] weight_base = '0;
    logic [AW-1:0] bias_base = '0;
    logic [AW-1:0] opsum_base = '0;
    logic [AW-1:0] ifmap_stride = '0;
    logic [AW-1:0] weight_stride = '0;
    logic [AW-1:0] bias_stride = '0;
    logic [AW-1:0] opsum_stride = '0;
    logic          pass_done = 1'b0;

    logic          PASS_START;
    logic [1:0]    pass_layer_type;
    logic [BW-1:0] pass_tile_n;
    logic [FW-1:0] pass_flags;
    logic [AW-1:0] BASE_IFMAP;
    logic [AW-1:0] BASE_WEIGHT;
    logic [AW-1:0] BASE_BIAS;
    logic [AW-1:0] BASE_OPSUM;
    logic          layer_busy;
    logic          layer_done;
    logic [CW-1:0] cur_k_idx;
    logic [CW-1:0] cur_d_idx;

    pass_scheduler #(
        .ADDR_WIDTH(AW), .BYTE_CNT_WIDTH(BW), .FLAG_WIDTH(FW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .layer_start(layer_start), .layer_abort(layer_abort), .layer_type(layer_type),
        .num_k_tiles(num_k_tiles), .num_d_tiles(num_d_tiles), .tile_n(tile_n),
        .ifmap_base(ifmap_base), .weight_base(weight_base),
        .bias_base(bias_base), .opsum_base(opsum_base),
        .ifmap_stride(ifmap_stride), .weight_stride(weight_stride),
        .bias_stride(bias_stride), .opsum_stride(opsum_stride),
        .PASS_START(PASS_START), .pass_layer_type(pass_layer_type),
        .pass_tile_n(pass_tile_n), .pass_flags(pass_flags),
        .BASE_IFMAP(BASE_IFMAP), .BASE_WEIGHT(BASE_WEIGHT),
        .BASE_BIAS(BASE_BIAS), .BASE_OPSUM(BASE_OPSUM),
        .pass_done(pass_done), .layer_busy(layer_busy), .layer_done(layer_done),
        .cur_k_idx(cur_k_idx), .cur_d_idx(cur_d_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ifm;
        logic [31:0] wt;
        logic [31:0] bs;
        logic [31:0] op;
        logic [3:0]  fl;
        logic [7:0]  k;
        logic [7:0]  d;
    } pass_t;

    pass_t       exp_q[$];
    pass_t       log_p[$];
    pass_t       cur;
    bit          hold_valid = 1'b0;
    bit          done_armed = 1'b0;
    logic [1:0]  exp_lt;
    logic [15:0] exp_tn;
    int          n_checks = 0;
    int          n_fail = 0;
    int          done_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Expected pass list from the closed-form rules (multiplication is fine here).
    task automatic build_model();
        pass_t p;
        int nk;
        int nd;
        nk = int'(num_k_tiles);
        nd = int'(num_d_tiles);
        exp_q.delete();
        hold_valid = 1'b0;
        done_armed = 1'b1;
        exp_lt = layer_type;
        exp_tn = tile_n;
        for (int k = 0; k < nk; k++) begin
            for (int d = 0; d < nd; d++) begin
                p.ifm = ifmap_base + 32'(d) * ifmap_stride;
                p.wt  = weight_base + 32'(k * nd + d) * weight_stride;
                p.bs  = bias_base + 32'(k) * bias_stride;
                p.op  = opsum_base + 32'(k) * opsum_stride;
                p.fl  = {(d == nd - 1), (d == 0), 2'b11};
                p.k   = 8'(k);
                p.d   = 8'(d);
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic check_outputs(input string pre);
        check({pre, "_ifmap"},  64'(BASE_IFMAP),  64'(cur.ifm));
        check({pre, "_weight"}, 64'(BASE_WEIGHT), 64'(cur.wt));
        check({pre, "_bias"},   64'(BASE_BIAS),   64'(cur.bs));
        check({pre, "_opsum"},  64'(BASE_OPSUM),  64'(cur.op));
        check({pre, "_flags"},  64'(pass_flags),  64'(cur.fl));
        check({pre, "_kidx"},   64'(cur_k_idx),   64'(cur.k));
        check({pre, "_didx"},   64'(cur_d_idx),   64'(cur.d));
        check({pre, "_ltype"},  64'(pass_layer_type), 64'(exp_lt));
        check({pre, "_tile_n"}, 64'(pass_tile_n), 64'(exp_tn));
    endtask

    // Compare process: every pass request and every held cycle against the model.
    always @(negedge clk) begin
        if (rst) begin
            if (PASS_START) begin
                check("pass_start_legal", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    hold_valid = 1'b1;
                    check_outputs("pass");
                end
            end else if (hold_valid && layer_busy) begin
                check_outputs("hold");
            end
            if (layer_done) begin
                done_count++;
                check("layer_done_legal", 64'(done_armed && (exp_q.size() == 0)), 64'd1);
                done_armed = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_desc(input int nk, input int nd,
                            input logic [31:0] ib, input logic [31:0] wb,
                            input logic [31:0] bb, input logic [31:0] ob,
                            input logic [31:0] is, input logic [31:0] ws,
                            input logic [31:0] bs, input logic [31:0] os);
        num_k_tiles   = 8'(nk);
        num_d_tiles   = 8'(nd);
        ifmap_base    = ib;
        weight_base   = wb;
        bias_base     = bb;
        opsum_base    = ob;
        ifmap_stride  = is;
        weight_stride = ws;
        bias_stride   = bs;
        opsum_stride  = os;
        layer_type    = 2'd2;
        tile_n        = 16'h0123;
    endtask

    task automatic start_layer();
        build_model();
        layer_start = 1'b1;
    endtask

    // Plays token_engine: pass_done 'gap' cycles after each PASS_START.
    task automatic serve(input int gap, input int abort_pass, input bit inject,
                         output int passes, output int first_ps, output int pd_cyc,
                         output int done_cyc, output bit busy_after);
        int cyc;
        bit fin;
        bit aborting;
        pass_t p;
        cyc = 0;
        fin = 1'b0;
        aborting = 1'b0;
        passes = 0;
        first_ps = -1;
        pd_cyc = -1;
        done_cyc = -1;
        busy_after = 1'b1;
        log_p.delete();
        while (!fin) begin
            tick();
            cyc++;
            layer_start = 1'b0;
            pass_done   = 1'b0;
            layer_abort = 1'b0;
            if (aborting) begin
                check("abort_busy", 64'(layer_busy), 64'd0);
                repeat (20) tick();
                fin = 1'b1;
            end else if (cyc > 3000) begin
                fail_now("serve_timeout");
                fin = 1'b1;
            end else if (layer_done) begin
                done_cyc = cyc;
                tick();
                busy_after = layer_busy;
                fin = 1'b1;
            end else if (PASS_START) begin
                passes++;
                if (first_ps < 0) first_ps = cyc;
                p.ifm = BASE_IFMAP;
                p.wt  = BASE_WEIGHT;
                p.bs  = BASE_BIAS;
                p.op  = BASE_OPSUM;
                p.fl  = pass_flags;
                p.k   = cur_k_idx;
                p.d   = cur_d_idx;
                log_p.push_back(p);
                if (inject && passes == 1) pass_done = 1'b1;
                for (int i = 1; i <= gap; i++) begin
                    tick();
                    cyc++;
                    pass_done = 1'b0;
                    if (inject && passes == 1) begin
                        if (i == 1) begin
                            layer_start = 1'b1;
                            num_k_tiles = 8'd5;
                            ifmap_base  = 32'hDEAD_0000;
                        end
                        if (i == 2) layer_start = 1'b0;
                    end
                end
                pass_done = 1'b1;
                pd_cyc = cyc;
                if (passes == abort_pass) begin
                    layer_abort = 1'b1;
                    aborting = 1'b1;
                    exp_q.delete();
                    done_armed = 1'b0;
                end
            end
        end
    endtask

    int passes;
    int first_ps;
    int pd_cyc;
    int done_cyc;
    bit busy_after;
    int done_before;

    initial begin
        #1;
        check("reset_pass_start", 64'(PASS_START), 64'd0);
        check("reset_busy", 64'(layer_busy), 64'd0);
        check("reset_weight", 64'(BASE_WEIGHT), 64'd0);
        tick();
        rst = 1'b1;
        tick();

        // 2x2 baseline
        set_desc(2, 2, 0, 64, 128, 192, 16, 16, 16, 16);
        start_layer();
        done_before = done_count;
        serve(5, -1, 1'b0, passes, first_ps, pd_cyc, done_cyc, busy_after);
        check("t1_passes", 64'(passes), 64'd4);
        check("t1_first_latency", 64'(first_ps), 64'd1);
        check("t1_done_latency", 64'(done_cyc - pd_cyc), 64'd2);
        check("t1_busy_low", 64'(busy_after), 64'd0);
        check("t1_done_count", 64'(done_count - done_before), 64'd1);
        if (log_p.size() == 4) begin
            check("t1_p1_ifmap", 64'(log_p[1].ifm), 64'd16);
            check("t1_p1_weight", 64'(log_p[1].wt), 64'd80);
            check("t1_p1_flags", 64'(log_p[1].fl), 64'hB);
            check("t1_p2_weight", 64'(log_p[2].wt), 64'd96);
            check("t1_p2_bias", 64'(log_p[2].bs), 64'd144);
            check("t1_p2_opsum", 64'(log_p[2].op), 64'd208);
            check("t1_p2_flags", 64'(log_p[2].fl), 64'h7);
            check("t1_p3_weight", 64'(log_p[3].wt), 64'd112);
        end
        repeat (3) tick();

        // 2x2 with stray layer_start in WAIT and pass_done in ISSUE
        set_desc(2, 2, 0, 64, 128, 192, 16, 16, 16, 16);
        start_layer();
        serve(5, -1, 1'b1, passes, first_ps, pd_cyc, done_cyc, busy_after);
        check("inj_passes", 64'(passes), 64'd4);
        if (log_p.size() == 4) begin
            check("inj_p2_ifmap", 64'(log_p[2].ifm), 64'd0);
            check("inj_p3_opsum", 64'(log_p[3].op), 64'd208);
        end
        repeat (3) tick();

        // num_d_tiles = 1, num_k_tiles = 3
        set_desc(3, 1, 0, 64, 128, 192, 16, 16, 16, 16);
        start_layer();
        serve(5, -1, 1'b0, passes, first_ps, pd_cyc, done_cyc, busy_after);
        check("t2_passes", 64'(passes), 64'd3);
        for (int i = 0; i < log_p.size(); i++) begin
            check("t2_flags", 64'(log_p[i].fl), 64'hF);
            check("t2_opsum", 64'(log_p[i].op), 64'(192 + 16 * i));
        end
        repeat (3) tick();

        // zero tile count
        set_desc(0, 4, 0, 64, 128, 192, 16, 16, 16, 16);
        start_layer();
        done_before = done_count;
        serve(5, -1, 1'b0, passes, first_ps, pd_cyc, done_cyc, busy_after);
        check("zero_passes", 64'(passes), 64'd0);
        check("zero_done_latency", 64'(done_cyc), 64'd1);
        check("zero_done_count", 64'(done_count - done_before), 64'd1);
        repeat (3) tick();

        // abort coincident with pass_done on pass 2 of 4
        set_desc(2, 2, 0, 64, 128, 192, 16, 16, 16, 16);
        start_layer();
        done_before = done_count;
        serve(5, 2, 1'b0, passes, first_ps, pd_cyc, done_cyc, busy_after);
        check("abort_passes", 64'(passes), 64'd2);
        check("abort_no_done", 64'(done_count - done_before), 64'd0);
        repeat (3) tick();

        // weight address wrap
        set_desc(1, 2, 0, 32'hFFFF_FFF0, 128, 192, 16, 16, 16, 16);
        start_layer();
        serve(5, -1, 1'b0, passes, first_ps, pd_cyc, done_cyc, busy_after);
        check("wrap_passes", 64'(passes), 64'd2);
        if (log_p.size() == 2) begin
            check("wrap_p0_weight", 64'(log_p[0].wt), 64'hFFFF_FFF0);
            check("wrap_p1_weight", 64'(log_p[1].wt), 64'd0);
        end
        repeat (3) tick();

        // reset mid-WAIT, then restart
        set_desc(2, 2, 0, 64, 128, 192, 16, 16, 16, 16);
        start_layer();
        tick();
        layer_start = 1'b0;
        for (int i = 0; i < 20 && !PASS_START; i++) tick();
        check("rst_seen_pass", 64'(PASS_START), 64'd1);
        tick();
        tick();
        exp_q.delete();
        hold_valid = 1'b0;
        done_armed = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        check("rst_busy", 64'(layer_busy), 64'd0);
        check("rst_ifmap", 64'(BASE_IFMAP), 64'd0);
        check("rst_weight", 64'(BASE_WEIGHT), 64'd0);
        check("rst_bias", 64'(BASE_BIAS), 64'd0);
        check("rst_opsum", 64'(BASE_OPSUM), 64'd0);
        check("rst_flags", 64'(pass_flags), 64'd0);
        check("rst_tile_n", 64'(pass_tile_n), 64'd0);
        check("rst_ltype", 64'(pass_layer_type), 64'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        set_desc(2, 2, 0, 64, 128, 192, 16, 16, 16, 16);
        start_layer();
        serve(5, -1, 1'b0, passes, first_ps, pd_cyc, done_cyc, busy_after);
        check("rst_restart_passes", 64'(passes), 64'd4);
        if (log_p.size() > 0) begin
            check("rst_restart_ifmap", 64'(log_p[0].ifm), 64'd0);
            check("rst_restart_weight", 64'(log_p[0].wt), 64'd64);
            check("rst_restart_kd", 64'({log_p[0].k, log_p[0].d}), 64'd0);
        end
        check("model_drained", 64'(exp_q.size()), 64'd0);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
